bw_mul: RTL and testbench

- Registered signed fixed-point multiplier built as a Baugh-Wooley two's-complement array.
- Instanced three-wide in the SGD datapath for the y_cap dot-product terms and the weight-update terms.
- Takes two LENGTH-bit signed operands and forms the exact 2*LENGTH-bit product.
- Rescales the product by FRAC, saturates it to LENGTH bits, and presents it one clock later.

---
 rtl/bw_mul_if.sv | 23 ++
 rtl/bw_mul.sv | 72 +++++++
 tb/tb_bw_mul.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bw_mul_if.sv
// Operand/result bundle for the Baugh-Wooley multiplier.
// The master drives the operands and in_valid; the slave returns the registered results.
interface bw_mul_if #(
    parameter int LENGTH = 16
);
    logic                  in_valid;
    logic [LENGTH-1:0]     a;
    logic [LENGTH-1:0]     b;
    logic [LENGTH-1:0]     p;
    logic [2*LENGTH-1:0]   p_full;
    logic                  ovf;
    logic                  out_valid;

    modport master (
        output in_valid, a, b,
        input  p, p_full, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b,
        output p, p_full, ovf, out_valid
    );
endinterface

// File: rtl/bw_mul.sv
// Signed fixed-point multiplier: Baugh-Wooley array, rescale by FRAC, saturate to LENGTH bits.
// Latency 1 cycle; one operation per cycle.
// No backpressure: results register whenever in_valid is high and hold otherwise.
module bw_mul #(
    parameter int LENGTH = 16,
    parameter int FRAC   = 8
) (
    input  logic     CLK,
    input  logic     RST,
    bw_mul_if.slave  bus
);
    localparam int W = 2 * LENGTH;
    // Baugh-Wooley correction terms at bit LENGTH and bit 2*LENGTH-1
    localparam logic [W-1:0] BW_CONST = (W'(1) << LENGTH) | (W'(1) << (W - 1));

    logic [W-1:0]        row;
    logic [W-1:0]        cs_s;
    logic [W-1:0]        cs_c;
    logic [W-1:0]        cs_t;
    logic [W-1:0]        prod;
    logic signed [W-1:0] s;
    logic [W-LENGTH:0]   hi;
    logic                sat;
    logic [LENGTH-1:0]   p_nxt;

    // Each partial-product row is folded into a carry-save pair; one carry-propagate add at the end.
    always_comb begin
        cs_s = BW_CONST;
        cs_c = '0;
        cs_t = '0;
        row  = '0;
        for (int j = 0; j < LENGTH; j++) begin
            row = '0;
            for (int i = 0; i < LENGTH; i++) begin
                row[i+j] = (bus.a[i] & bus.b[j]) ^ ((i == LENGTH - 1) != (j == LENGTH - 1));
            end
            cs_t = cs_s ^ cs_c ^ row;
            cs_c = ((cs_s & cs_c) | (cs_s & row) | (cs_c & row)) << 1;
            cs_s = cs_t;
        end
        prod = cs_s + cs_c;
    end

    assign s = $signed(prod) >>> FRAC;

    // s fits in LENGTH bits only when every bit from LENGTH-1 upward matches the sign
    assign hi  = s[W-1:LENGTH-1];
    assign sat = (|hi) & ~(&hi);

    always_comb begin
        p_nxt = s[LENGTH-1:0];
        if (sat) begin
            p_nxt = s[W-1] ? {1'b1, {(LENGTH-1){1'b0}}} : {1'b0, {(LENGTH-1){1'b1}}};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.p         <= '0;
            bus.p_full    <= '0;
            bus.ovf       <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.p      <= p_nxt;
                bus.p_full <= prod;
                bus.ovf    <= sat;
            end
        end
    end
endmodule

// File: tb/tb_bw_mul.sv
// Bench for bw_mul: two instances (FRAC=8 and FRAC=0) share one operand stream
// and are compared against an arithmetic reference model.
module tb_bw_mul;
    logic CLK = 1'b0;
    logic RST = 1'b1;

    logic [15:0] ta = '0;
    logic [15:0] tb_ = '0;
    logic        tv = 1'b0;

    logic [15:0] last_a = '0;
    logic [15:0] last_b = '0;

    int checks = 0;
    int errors = 0;

    bw_mul_if #(.LENGTH(16)) if8 ();
    bw_mul_if #(.LENGTH(16)) if0 ();

    assign if8.a = ta;
    assign if8.b = tb_;
    assign if8.in_valid = tv;
    assign if0.a = ta;
    assign if0.b = tb_;
    assign if0.in_valid = tv;

    bw_mul #(.LENGTH(16), .FRAC(8)) dut8 (.CLK(CLK), .RST(RST), .bus(if8));
    bw_mul #(.LENGTH(16), .FRAC(0)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));

    always #5 CLK = ~CLK;

    function automatic longint m_full(input logic [15:0] a, input logic [15:0] b);
        longint la;
        longint lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        return la * lb;
    endfunction

    // {ovf, p}: floor-divide by 2^frac, then clamp to 16-bit signed
    function automatic logic [16:0] m_sat(input longint full, input int frac);
        longint s;
        logic [15:0] lo;
        s = full >>> frac;
        if (s > 64'sd32767) return {1'b1, 16'h7FFF};
        if (s < -64'sd32768) return {1'b1, 16'h8000};
        lo = s[15:0];
        return {1'b0, lo};
    endfunction

    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic v);
        @(negedge CLK);
        ta = a;
        tb_ = b;
        tv = v;
        if (v) begin
            last_a = a;
            last_b = b;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        checks++;
        if (if8.p !== 16'h0 || if8.p_full !== 32'h0 || if8.ovf !== 1'b0 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: p=%h p_full=%h ovf=%b vld=%b, need all zero", if8.p, if8.p_full, if8.ovf, if8.out_valid);
        end
        @(negedge CLK);
        RST = 1'b0;
        step(16'h1234, 16'h0100, 1'b1);
        checks++;
        if (if8.p !== 16'h1234 || if8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_first: p=%h vld=%b, need 1234/1", if8.p, if8.out_valid);
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if (if8.p !== 16'h0 || if8.p_full !== 32'h0 || if8.ovf !== 1'b0 || if8.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: p=%h p_full=%h ovf=%b vld=%b, need all zero", if8.p, if8.p_full, if8.ovf, if8.out_valid);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (if8.p !== 16'h1234 || if8.p_full !== 32'h00123400 || if8.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: p=%h p_full=%h vld=%b, need 1234/00123400/1", if8.p, if8.p_full, if8.out_valid);
        end
    endtask

    task automatic test_directed();
        logic [15:0] va [7] = '{16'h0100, 16'hFF00, 16'h0001, 16'h0001, 16'h7FFF, 16'h8000, 16'h8000};
        logic [15:0] vb [7] = '{16'h0200, 16'h0180, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h7FFF};
        logic [15:0] vp [7] = '{16'h0200, 16'hFE80, 16'h0000, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h8000};
        logic [31:0] vf [7] = '{32'h00020000, 32'hFFFE8000, 32'h00000001, 32'hFFFFFFFF,
                                32'h3FFF0001, 32'h40000000, 32'hC0008000};
        logic        vo [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [16:0] e0;
        for (int k = 0; k < 7; k++) begin
            step(va[k], vb[k], 1'b1);
            checks++;
            if (if8.p !== vp[k] || if8.p_full !== vf[k] || if8.ovf !== vo[k] || if8.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed%0d: p=%h p_full=%h ovf=%b vld=%b, need %h/%h/%b/1",
                         k, if8.p, if8.p_full, if8.ovf, if8.out_valid, vp[k], vf[k], vo[k]);
            end
            e0 = m_sat(m_full(va[k], vb[k]), 0);
            checks++;
            if (if0.p !== e0[15:0] || if0.ovf !== e0[16] || if0.p_full !== vf[k]) begin
                errors++;
                $display("FAIL directed_frac0_%0d: p=%h ovf=%b p_full=%h, need %h/%b/%h",
                         k, if0.p, if0.ovf, if0.p_full, e0[15:0], e0[16], vf[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra;
        logic [15:0] rb;
        logic [16:0] e8;
        for (int k = 0; k < 3; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            step(ra, rb, 1'b1);
            e8 = m_sat(m_full(ra, rb), 8);
            checks++;
            if (if8.out_valid !== 1'b1 || if8.p !== e8[15:0] || if8.p_full !== 32'(m_full(ra, rb))) begin
                errors++;
                $display("FAIL b2b%0d: vld=%b p=%h p_full=%h, need 1/%h/%h",
                         k, if8.out_valid, if8.p, if8.p_full, e8[15:0], 32'(m_full(ra, rb)));
            end
        end
        for (int k = 0; k < 2; k++) begin
            step(16'($urandom), 16'($urandom), 1'b0);
            checks++;
            if (if8.out_valid !== 1'b0 || if8.p !== e8[15:0] || if8.p_full !== 32'(m_full(last_a, last_b))) begin
                errors++;
                $display("FAIL hold%0d: vld=%b p=%h p_full=%h, need 0/%h/%h",
                         k, if8.out_valid, if8.p, if8.p_full, e8[15:0], 32'(m_full(last_a, last_b)));
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] corners [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rv;
        longint      full;
        logic [16:0] e8;
        logic [16:0] e0;
        for (int k = 0; k < 10000; k++) begin
            ra = ($urandom_range(0, 15) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? corners[$urandom_range(0, 3)] : 16'($urandom);
            rv = ($urandom_range(0, 7) != 0);
            step(ra, rb, rv);
            full = m_full(last_a, last_b);
            e8 = m_sat(full, 8);
            e0 = m_sat(full, 0);
            checks++;
            if (if8.out_valid !== rv || if8.p !== e8[15:0] || if8.ovf !== e8[16] || if8.p_full !== 32'(full)) begin
                errors++;
                $display("FAIL rand8_%0d: vld=%b p=%h ovf=%b p_full=%h, need %b/%h/%b/%h",
                         k, if8.out_valid, if8.p, if8.ovf, if8.p_full, rv, e8[15:0], e8[16], 32'(full));
            end
            checks++;
            if (if0.out_valid !== rv || if0.p !== e0[15:0] || if0.ovf !== e0[16] || if0.p_full !== 32'(full)) begin
                errors++;
                $display("FAIL rand0_%0d: vld=%b p=%h ovf=%b p_full=%h, need %b/%h/%b/%h",
                         k, if0.out_valid, if0.p, if0.ovf, if0.p_full, rv, e0[15:0], e0[16], 32'(full));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
